mul_arbiter: RTL and testbench
==============================

# mul_arbiter

Shares one multicycle `multiplier` instance between two requesters: the integer execute stage (requester 0) and the address-generation/CSR helper path (requester 1). It arbitrates round-robin and sequences the multiplier's start/finish handshake. It holds the operation and operands stable for the whole computation and returns the result to the granted requester through a valid/ready response. It sits between the requesters and the multiplier; the multiplier's ports connect only to this block.

## Interface
Parameters:
- `XLEN` — default `XLEN_WIDTH` from `common`; operand and result width.

Ports:
- `clk`, in, 1 — clock.
- `reset_n`, in, 1 — reset, synchronous, active-low.
- `req_valid`, in, 2 — per-requester request valid.
- `req_ready`, out, 2 — per-requester request accepted this cycle; one-hot or zero.
- `req_op0`, `req_op1`, in, `alu_op_type` — operation (`ALU_MUL`, `ALU_MULH`, ...).
- `req_a0`, `req_b0`, `req_a1`, `req_b1`, in, `XLEN` — operands.
- `flush`, in, 2 — per-requester kill of its outstanding operation.
- `resp_valid`, out, 2 — per-requester result valid; one-hot or zero.
- `resp_ready`, in, 2 — per-requester result consumed.
- `resp_result`, out, `XLEN` — registered result, shared by both requesters.
- `busy`, out, 1 — high in every state except IDLE.
- `mul_start`, out, 1 — connects to `multiplier.start`.
- `mul_operation`, out, `alu_op_type` — connects to `multiplier.operation`.
- `mul_operand1`, `mul_operand2`, out, `XLEN` — connect to the multiplier's operand inputs.
- `mul_result`, in, `XLEN` — from the multiplier.
- `mul_finish`, in, 1 — from the multiplier.
- `mul_ready`, in, 1 — from the multiplier.

## Operation
- State machine: IDLE, START, WAIT, RESP.
- Registers: `gnt` (1 bit, granted requester), `rr_ptr` (1 bit, priority holder), `kill` (1 bit), op/operand capture registers, result register.
- IDLE:
  - Eligible requester i: `req_valid[i] && !flush[i]`.
  - Grant only when `mul_ready=1`.
  - If both are eligible, grant `rr_ptr`; otherwise grant the one eligible requester.
  - `req_ready[gnt]=1` combinationally in that cycle.
  - On acceptance: capture op/a/b, `gnt<=i`, `rr_ptr<=~i`, `kill<=0`, go to START.
- START: `mul_start=1` for exactly one cycle, then go to WAIT.
- WAIT:
  - Wait for `mul_finish`.
  - On `mul_finish`: if `kill` is set, go to IDLE with no response. Otherwise latch `mul_result` into `resp_result` and go to RESP.
- RESP:
  - `resp_valid[gnt]=1`.
  - On `resp_ready[gnt]` or `flush[gnt]`, go to IDLE.
- `mul_operation` and `mul_operand1/2` are driven from the capture registers in all states. They stay stable from START through the cycle `mul_finish` is sampled, because the multiplier selects its result half combinationally from `operation`.
- Flush:
  - `flush[gnt]` in START or WAIT sets `kill`.
  - The multiplier cannot be aborted, so the block still waits for `mul_finish`.
  - `flush` for the non-granted requester has no effect.
- Arithmetic: none in this block; the result is passed through bit-exact.

## Timing
- Reset values:
  - State IDLE; `rr_ptr=0`, `gnt=0`, `kill=0`.
  - `req_ready=0` when `req_valid=0`; `resp_valid=0`, `resp_result=0`, `busy=0`, `mul_start=0`.
  - `mul_operation` and operands 0.
- Request acceptance, counted from the accept cycle T:
  - `mul_start` is high in T+1.
  - The multiplier is busy for N=ceil(XLEN/CHUNK_WIDTH) cycles, and `mul_finish` is high in T+2+N.
  - `resp_valid` is high from T+3+N.
  - With XLEN=32 and CHUNK_WIDTH=8, `resp_valid` is high at T+7.
- Throughput: at most one operation in flight. The next acceptance is possible, at the earliest, in the cycle after RESP handshakes.
- Backpressure: while `resp_ready` is low, `resp_valid` and `resp_result` hold, and `req_ready` stays 0.
- Simultaneous `flush[gnt]` and `resp_ready[gnt]` in RESP: go to IDLE; counts as a consumed response.
- `flush[gnt]` in the same cycle `mul_finish` arrives: suppress the response; go to IDLE.
- Reset mid-operation:
  - Every register returns to its reset value on the next edge.
  - The multiplier shares `reset_n`, so no stale `mul_finish` follows.

## Test plan
- Single operation: req0 `ALU_MUL` a=7, b=0xFFFFFFFD, accepted at T -> `mul_start` high at T+1, `resp_valid[0]` high at T+7, `resp_result`=0xFFFFFFEB.
- MULH: req1 `ALU_MULH` a=0x80000000, b=0x80000000 -> `resp_valid[1]`, `resp_result`=0x40000000; `mul_operation` stable through the finish cycle.
- Contention: both `req_valid` held high for 4 operations from reset with `resp_ready`=11 -> grant order 0,1,0,1; `req_ready` is never 11.
- Backpressure: `resp_ready[0]`=0 for 5 cycles in RESP -> `resp_valid[0]` and `resp_result` stable, `req_ready`=00 and `busy`=1 throughout; release -> IDLE next cycle.
- Flush: `flush[0]` pulsed in WAIT -> no `resp_valid`; state returns to IDLE the cycle after `mul_finish`; a following req1 MUL 3*5 returns 15.
- Reset: `reset_n` low during WAIT -> next cycle IDLE, all outputs at reset values; a subsequent req0 MUL 2*2 returns 4.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin share of one multicycle multiplier between two requesters; accept at T, mul_start at T+1, resp at T+3+N.
// One op in flight; resp_valid/resp_result hold until resp_ready, and no request is accepted meanwhile.
package common;
  localparam int XLEN_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_MUL,
    ALU_MULH,
    ALU_MULHSU,
    ALU_MULHU
  } alu_op_type;
endpackage

module mul_arbiter #(
  parameter int XLEN = common::XLEN_WIDTH,
  parameter int OP_W = $bits(common::alu_op_type)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [OP_W-1:0] req_op0,
  input  logic [OP_W-1:0] req_op1,
  input  logic [XLEN-1:0] req_a0,
  input  logic [XLEN-1:0] req_b0,
  input  logic [XLEN-1:0] req_a1,
  input  logic [XLEN-1:0] req_b1,
  input  logic [1:0]      flush,
  output logic [1:0]      resp_valid,
  input  logic [1:0]      resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy,
  output logic            mul_start,
  output logic [OP_W-1:0] mul_operation,
  output logic [XLEN-1:0] mul_operand1,
  output logic [XLEN-1:0] mul_operand2,
  input  logic [XLEN-1:0] mul_result,
  input  logic            mul_finish,
  input  logic            mul_ready
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  state_t          state_q;
  logic            gnt_q;
  logic            rr_ptr_q;
  logic            kill_q;
  logic [OP_W-1:0] op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] result_q;
  logic [1:0]      resp_valid_q;
  logic            mul_start_q;
  logic            busy_q;

  logic [1:0]      elig;
  logic            gnt_d;
  logic            accept;

  // Contention goes to the pointer holder; otherwise the single eligible requester wins.
  always_comb begin
    elig   = req_valid & ~flush;
    gnt_d  = (elig == 2'b11) ? rr_ptr_q : elig[1];
    accept = reset_n && (state_q == IDLE) && mul_ready && (elig != 2'b00);
  end

  assign req_ready     = accept ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
  assign resp_valid    = resp_valid_q;
  assign resp_result   = result_q;
  assign busy          = busy_q;
  assign mul_start     = mul_start_q;
  assign mul_operation = op_q;
  assign mul_operand1  = a_q;
  assign mul_operand2  = b_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      rr_ptr_q     <= 1'b0;
      kill_q       <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      resp_valid_q <= 2'b00;
      mul_start_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q        <= gnt_d ? req_op1 : req_op0;
            a_q         <= gnt_d ? req_a1 : req_a0;
            b_q         <= gnt_d ? req_b1 : req_b0;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= ~gnt_d;
            kill_q      <= 1'b0;
            mul_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          mul_start_q <= 1'b0;
          if (flush[gnt_q]) kill_q <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          // The multiplier cannot be aborted, so a killed op still waits out mul_finish.
          if (mul_finish) begin
            if (kill_q || flush[gnt_q]) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              result_q     <= mul_result;
              resp_valid_q <= gnt_q ? 2'b10 : 2'b01;
              state_q      <= RESP;
            end
          end else if (flush[gnt_q]) begin
            kill_q <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready[gnt_q] || flush[gnt_q]) begin
            resp_valid_q <= 2'b00;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a 4-cycle behavioural multiplier (XLEN=32, CHUNK_WIDTH=8).
module tb_mul_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, flush, resp_valid, resp_ready;
  logic [3:0]  req_op0, req_op1, mul_operation;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [31:0] resp_result, mul_operand1, mul_operand2, mul_result;
  logic        busy, mul_start, mul_finish, mul_ready;

  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_MULH = 4'd3;

  int tests = 0;
  int fails = 0;

  mul_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .busy(busy),
    .mul_start(mul_start), .mul_operation(mul_operation),
    .mul_operand1(mul_operand1), .mul_operand2(mul_operand2),
    .mul_result(mul_result), .mul_finish(mul_finish), .mul_ready(mul_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: busy 4 cycles after start, result half picked from live operation.
  logic [2:0]  m_cnt;
  logic        m_fin;
  logic [31:0] m_a, m_b;
  logic [63:0] p_ss, p_su, p_uu;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_cnt <= 3'd0;
      m_fin <= 1'b0;
      m_a   <= 32'd0;
      m_b   <= 32'd0;
    end else begin
      m_fin <= 1'b0;
      if (mul_start) begin
        m_cnt <= 3'd4;
        m_a   <= mul_operand1;
        m_b   <= mul_operand2;
      end else if (m_cnt != 3'd0) begin
        m_cnt <= m_cnt - 3'd1;
        if (m_cnt == 3'd1) m_fin <= 1'b1;
      end
    end
  end

  always_comb begin
    p_ss = {{32{m_a[31]}}, m_a} * {{32{m_b[31]}}, m_b};
    p_su = {{32{m_a[31]}}, m_a} * {32'd0, m_b};
    p_uu = {32'd0, m_a} * {32'd0, m_b};
    mul_result = 32'd0;
    if (m_fin) begin
      case (mul_operation)
        4'd3:    mul_result = p_ss[63:32];
        4'd4:    mul_result = p_su[63:32];
        4'd5:    mul_result = p_uu[63:32];
        default: mul_result = p_ss[31:0];
      endcase
    end
  end

  assign mul_finish = m_fin;
  assign mul_ready  = (m_cnt == 3'd0) && !m_fin;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic run_op(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [1:0] rdy, output int lat, output logic [1:0] rv, output logic [31:0] res);
    resp_ready = 2'b11;
    if (r == 0) begin
      req_op0 = op; req_a0 = a; req_b0 = b; req_valid = 2'b01;
    end else begin
      req_op1 = op; req_a1 = a; req_b1 = b; req_valid = 2'b10;
    end
    #1;
    rdy = req_ready;
    tick();
    req_valid = 2'b00;
    lat = 1;
    while (resp_valid == 2'b00 && lat < 30) begin
      tick();
      lat++;
    end
    rv  = resp_valid;
    res = resp_result;
    tick();
  endtask

  task automatic test_reset;
    apply_reset();
    tests++; if (req_ready !== 2'b00)     begin fails++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    tests++; if (resp_valid !== 2'b00)    begin fails++; $display("FAIL reset_resp_valid got %b want 00", resp_valid); end
    tests++; if (resp_result !== 32'd0)   begin fails++; $display("FAIL reset_resp_result got %h want 0", resp_result); end
    tests++; if (busy !== 1'b0)           begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (mul_start !== 1'b0)      begin fails++; $display("FAIL reset_mul_start got %b want 0", mul_start); end
    tests++; if (mul_operation !== 4'd0)  begin fails++; $display("FAIL reset_mul_operation got %h want 0", mul_operation); end
    tests++; if ({mul_operand1, mul_operand2} !== 64'd0)
      begin fails++; $display("FAIL reset_operands got %h/%h want 0/0", mul_operand1, mul_operand2); end
  endtask

  task automatic test_single;
    int lat;
    resp_ready = 2'b01;
    req_op0 = OP_MUL; req_a0 = 32'd7; req_b0 = 32'hFFFF_FFFD; req_valid = 2'b01;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_req_ready got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tests++; if (mul_start !== 1'b1) begin fails++; $display("FAIL single_start_t1 got %b want 1", mul_start); end
    tests++; if (busy !== 1'b1)      begin fails++; $display("FAIL single_busy got %b want 1", busy); end
    tick();
    tests++; if (mul_start !== 1'b0) begin fails++; $display("FAIL single_start_t2 got %b want 0", mul_start); end
    lat = 2;
    while (resp_valid == 2'b00 && lat < 30) begin
      tick();
      lat++;
    end
    tests++; if (lat !== 7)                   begin fails++; $display("FAIL single_latency got %0d want 7", lat); end
    tests++; if (resp_valid !== 2'b01)        begin fails++; $display("FAIL single_resp_valid got %b want 01", resp_valid); end
    tests++; if (resp_result !== 32'hFFFF_FFEB) begin fails++; $display("FAIL single_result got %h want ffffffeb", resp_result); end
    tick();
    tests++; if (busy !== 1'b0 || resp_valid !== 2'b00)
      begin fails++; $display("FAIL single_idle got busy=%b rv=%b want 0/00", busy, resp_valid); end
  endtask

  task automatic test_mulh;
    int n;
    int unstable;
    resp_ready = 2'b11;
    req_op1 = OP_MULH; req_a1 = 32'h8000_0000; req_b1 = 32'h8000_0000; req_valid = 2'b10;
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL mulh_req_ready got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    unstable = 0;
    n = 0;
    while (n < 30) begin
      if (mul_operation !== OP_MULH) unstable++;
      if (mul_finish) break;
      tick();
      n++;
    end
    tests++; if (mul_finish !== 1'b1) begin fails++; $display("FAIL mulh_finish_timeout got %b want 1", mul_finish); end
    tests++; if (unstable !== 0)      begin fails++; $display("FAIL mulh_op_stable got %0d changes want 0", unstable); end
    tick();
    tests++; if (resp_valid !== 2'b10)          begin fails++; $display("FAIL mulh_resp_valid got %b want 10", resp_valid); end
    tests++; if (resp_result !== 32'h4000_0000) begin fails++; $display("FAIL mulh_result got %h want 40000000", resp_result); end
    tick();
  endtask

  task automatic test_contention;
    int grants[4];
    int gcyc[4];
    int ng;
    int nr;
    int both;
    apply_reset();
    resp_ready = 2'b11;
    req_op0 = OP_MUL; req_a0 = 32'd2; req_b0 = 32'd3;
    req_op1 = OP_MUL; req_a1 = 32'd4; req_b1 = 32'd5;
    req_valid = 2'b11;
    ng = 0; nr = 0; both = 0;
    for (int c = 0; c < 80 && nr < 4; c++) begin
      #1;
      if (req_ready == 2'b11) both++;
      if (req_ready != 2'b00 && ng < 4) begin
        grants[ng] = (req_ready == 2'b10) ? 1 : 0;
        gcyc[ng]   = c;
        ng++;
      end
      if (resp_valid != 2'b00) begin
        nr++;
        tests++;
        if (resp_valid == 2'b01 && resp_result !== 32'd6 || resp_valid == 2'b10 && resp_result !== 32'd20 ||
            resp_valid == 2'b11)
          begin fails++; $display("FAIL contention_result rv=%b got %h want 6 or 20 matching", resp_valid, resp_result); end
        if (nr == 4) req_valid = 2'b00;
      end
      tick();
    end
    tests++; if (ng !== 4)   begin fails++; $display("FAIL contention_grants got %0d want 4", ng); end
    tests++; if (both !== 0) begin fails++; $display("FAIL contention_ready_11 got %0d cycles want 0", both); end
    for (int i = 0; i < ng; i++) begin
      tests++;
      if (grants[i] !== (i % 2)) begin fails++; $display("FAIL contention_order[%0d] got %0d want %0d", i, grants[i], i % 2); end
    end
    for (int i = 1; i < ng; i++) begin
      tests++;
      if (gcyc[i] - gcyc[i-1] !== 8)
        begin fails++; $display("FAIL back_to_back_gap[%0d] got %0d want 8", i, gcyc[i] - gcyc[i-1]); end
    end
  endtask

  task automatic test_backpressure;
    int n;
    resp_ready = 2'b00;
    req_op0 = OP_MUL; req_a0 = 32'd6; req_b0 = 32'd7; req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b11;
    n = 0;
    while (resp_valid == 2'b00 && n < 30) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (resp_valid !== 2'b01)  begin fails++; $display("FAIL bp_resp_valid[%0d] got %b want 01", i, resp_valid); end
      tests++; if (resp_result !== 32'd42) begin fails++; $display("FAIL bp_result[%0d] got %h want 2a", i, resp_result); end
      tests++; if (req_ready !== 2'b00)   begin fails++; $display("FAIL bp_req_ready[%0d] got %b want 00", i, req_ready); end
      tests++; if (busy !== 1'b1)         begin fails++; $display("FAIL bp_busy[%0d] got %b want 1", i, busy); end
      tick();
    end
    resp_ready = 2'b01;
    req_valid  = 2'b00;
    tick();
    tests++; if (busy !== 1'b0 || resp_valid !== 2'b00)
      begin fails++; $display("FAIL bp_release got busy=%b rv=%b want 0/00", busy, resp_valid); end
  endtask

  task automatic test_flush;
    int n;
    int leaked;
    logic [1:0]  rdy, rv;
    logic [31:0] res;
    int lat;
    resp_ready = 2'b11;
    req_op0 = OP_MUL; req_a0 = 32'd9; req_b0 = 32'd9; req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    flush = 2'b01;
    tick();
    flush = 2'b00;
    leaked = 0;
    n = 0;
    while (!mul_finish && n < 30) begin
      if (resp_valid != 2'b00) leaked++;
      tick();
      n++;
    end
    tests++; if (mul_finish !== 1'b1) begin fails++; $display("FAIL flush_finish_timeout got %b want 1", mul_finish); end
    tick();
    tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL flush_idle_busy got %b want 0", busy); end
    tests++; if (resp_valid !== 2'b00 || leaked !== 0)
      begin fails++; $display("FAIL flush_no_resp got rv=%b leaked=%0d want 00/0", resp_valid, leaked); end
    run_op(1, OP_MUL, 32'd3, 32'd5, rdy, lat, rv, res);
    tests++; if (rdy !== 2'b10)  begin fails++; $display("FAIL flush_next_ready got %b want 10", rdy); end
    tests++; if (rv !== 2'b10)   begin fails++; $display("FAIL flush_next_rv got %b want 10", rv); end
    tests++; if (res !== 32'd15) begin fails++; $display("FAIL flush_next_result got %h want f", res); end
  endtask

  task automatic test_flush_at_finish;
    int n;
    resp_ready = 2'b11;
    req_op1 = OP_MUL; req_a1 = 32'd11; req_b1 = 32'd2; req_valid = 2'b10;
    #1;
    tick();
    req_valid = 2'b00;
    n = 0;
    while (!mul_finish && n < 30) begin
      tick();
      n++;
    end
    flush = 2'b10;
    tick();
    flush = 2'b00;
    tests++; if (busy !== 1'b0 || resp_valid !== 2'b00)
      begin fails++; $display("FAIL flush_at_finish got busy=%b rv=%b want 0/00", busy, resp_valid); end
  endtask

  task automatic test_reset_mid;
    int leaked;
    logic [1:0]  rdy, rv;
    logic [31:0] res;
    int lat;
    resp_ready = 2'b11;
    req_op0 = OP_MUL; req_a0 = 32'd5; req_b0 = 32'd5; req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    tests++; if (busy !== 1'b0 || mul_start !== 1'b0 || resp_valid !== 2'b00 || req_ready !== 2'b00)
      begin fails++; $display("FAIL rst_mid_ctrl got busy=%b start=%b rv=%b rdy=%b want 0/0/00/00", busy, mul_start, resp_valid, req_ready); end
    tests++; if (resp_result !== 32'd0 || mul_operation !== 4'd0 || mul_operand1 !== 32'd0 || mul_operand2 !== 32'd0)
      begin fails++; $display("FAIL rst_mid_data got res=%h op=%h a=%h b=%h want 0", resp_result, mul_operation, mul_operand1, mul_operand2); end
    reset_n = 1'b1;
    leaked = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid != 2'b00 || mul_finish) leaked++;
      tick();
    end
    tests++; if (leaked !== 0) begin fails++; $display("FAIL rst_mid_stale got %0d want 0", leaked); end
    run_op(0, OP_MUL, 32'd2, 32'd2, rdy, lat, rv, res);
    tests++; if (rv !== 2'b01)  begin fails++; $display("FAIL rst_mid_next_rv got %b want 01", rv); end
    tests++; if (res !== 32'd4) begin fails++; $display("FAIL rst_mid_next_result got %h want 4", res); end
    tests++; if (lat !== 7)     begin fails++; $display("FAIL rst_mid_next_latency got %0d want 7", lat); end
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 2'b00; flush = 2'b00; resp_ready = 2'b00;
    req_op0 = 4'd0; req_op1 = 4'd0;
    req_a0 = 32'd0; req_b0 = 32'd0; req_a1 = 32'd0; req_b1 = 32'd0;
    test_reset();
    test_single();
    test_mulh();
    test_contention();
    test_backpressure();
    test_flush();
    test_flush_at_finish();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
